// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command, response and APB bus signals of apb_master
interface apb_master_if #(
   parameter int AW = 8,
   parameter int DW = 16
) ();
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata;
   logic          pready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester with wait-state timeout
module apb_master #(
   parameter int AW      = 8,
   parameter int DW      = 16,
   parameter int TIMEOUT = 16
) (
   input logic           pclk,
   input logic           rst,
   apb_master_if.master  bus
);
   localparam int              CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_psel;
   logic          r_penable;
   logic          r_cmd_ready;
   logic          r_rsp_valid;
   logic          r_pwrite;
   logic [AW-1:0] r_paddr;
   logic [DW-1:0] r_pwdata;
   logic [DW-1:0] r_rsp_rdata;
   logic          r_rsp_err;

   // Transfer sequencer; the handshake/select flags are registered alongside
   // the state so they mirror it exactly without decode glitches.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_pwrite <= bus.cmd_write;
                  r_paddr  <= bus.cmd_addr;
                  // Reads leave the previous write data on the bus.
                  if (bus.cmd_write) begin
                     r_pwdata <= bus.cmd_wdata;
                  end
                  r_state     <= S_SETUP;
                  r_psel      <= 1'b1;
                  r_cmd_ready <= 1'b0;
               end
            end
            S_SETUP: begin
               r_cnt     <= '0;
               r_state   <= S_ACCESS;
               r_penable <= 1'b1;
            end
            S_ACCESS: begin
               // pready takes priority over an expiring wait counter.
               if (bus.pready) begin
                  r_rsp_rdata <= r_pwrite ? '0 : bus.prdata;
                  r_rsp_err   <= 1'b0;
                  r_state     <= S_RESP;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= 1'b1;
               end else if (r_cnt == LAST) begin
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b1;
                  r_state     <= S_RESP;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_psel      <= 1'b0;
               r_penable   <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.cmd_ready = r_cmd_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.psel      = r_psel;
   assign bus.penable   = r_penable;
   assign bus.pwrite    = r_pwrite;
   assign bus.paddr     = r_paddr;
   assign bus.pwdata    = r_pwdata;
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized self-checking bench for apb_master
module tb_apb_master;
   localparam int AW      = 8;
   localparam int DW      = 16;
   localparam int TIMEOUT = 16;

   logic pclk = 1'b0;
   logic rst;

   always #5 pclk = ~pclk;

   apb_master_if #(.AW(AW), .DW(DW)) bus ();

   apb_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) u_dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: slave register file and last write data on the bus.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] exp_pwdata;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_junk_cmd(input logic valid);
      bus.cmd_valid = valid;
      bus.cmd_write = 1'(($urandom));
      bus.cmd_addr  = AW'($urandom);
      bus.cmd_wdata = DW'($urandom);
   endtask

   // One transfer; entered and left at a negedge with the DUT idle.
   // wait_n: ACCESS cycles with pready low before it rises.
   // hold_n: RESP cycles with rsp_ready low (junk command held meanwhile).
   task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int wait_n, input int hold_n);
      int            k;
      logic          err;
      int            exp_cycles;
      logic [DW-1:0] exp_rd;

      check_eq("idle_cmd_ready", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.pready    = 1'(($urandom));
      bus.prdata    = DW'($urandom);
      if (wr) exp_pwdata = wdata;

      @(negedge pclk);
      drive_junk_cmd(1'(($urandom)));
      check_eq("setup_psel",    bus.psel, 1);
      check_eq("setup_penable", bus.penable, 0);
      check_eq("setup_cmd_rdy", bus.cmd_ready, 0);
      check_eq("setup_paddr",   bus.paddr, addr);
      check_eq("setup_pwrite",  bus.pwrite, wr);
      check_eq("setup_pwdata",  bus.pwdata, exp_pwdata);
      bus.pready = 1'(($urandom));
      bus.prdata = DW'($urandom);

      k = 0;
      for (int i = 0; i < TIMEOUT + 4; i++) begin
         @(negedge pclk);
         if (!(bus.psel && bus.penable)) break;
         k++;
         check_eq("access_paddr",  bus.paddr, addr);
         check_eq("access_pwrite", bus.pwrite, wr);
         check_eq("access_pwdata", bus.pwdata, exp_pwdata);
         bus.pready = (k > wait_n);
         bus.prdata = bus.pready ? mem[addr] : DW'($urandom);
      end

      err        = (wait_n >= TIMEOUT);
      exp_cycles = err ? TIMEOUT : wait_n + 1;
      exp_rd     = (err || wr) ? '0 : mem[addr];
      bus.pready = 1'b0;
      check_eq("access_cycles", k, exp_cycles);
      check_eq("rsp_valid",     bus.rsp_valid, 1);
      check_eq("rsp_err",       bus.rsp_err, err);
      check_eq("rsp_rdata",     bus.rsp_rdata, exp_rd);
      check_eq("resp_psel",     bus.psel, 0);
      check_eq("resp_cmd_rdy",  bus.cmd_ready, 0);
      if (wr && !err) mem[addr] = wdata;

      for (int i = 0; i < hold_n; i++) begin
         bus.rsp_ready = 1'b0;
         drive_junk_cmd(1'b1);
         @(negedge pclk);
         check_eq("hold_rsp_valid", bus.rsp_valid, 1);
         check_eq("hold_rsp_err",   bus.rsp_err, err);
         check_eq("hold_rsp_rdata", bus.rsp_rdata, exp_rd);
         check_eq("hold_psel",      bus.psel, 0);
         check_eq("hold_cmd_rdy",   bus.cmd_ready, 0);
      end
      bus.rsp_ready = 1'b1;

      @(negedge pclk);
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b0;
      check_eq("done_rsp_valid", bus.rsp_valid, 0);
      check_eq("done_psel",      bus.psel, 0);
      check_eq("done_rdata_hold", bus.rsp_rdata, exp_rd);
      check_eq("done_err_hold",  bus.rsp_err, err);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_psel"},      bus.psel, 0);
      check_eq({tag, "_penable"},   bus.penable, 0);
      check_eq({tag, "_pwrite"},    bus.pwrite, 0);
      check_eq({tag, "_paddr"},     bus.paddr, 0);
      check_eq({tag, "_pwdata"},    bus.pwdata, 0);
      check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      check_eq({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
      check_eq({tag, "_rsp_err"},   bus.rsp_err, 0);
      check_eq({tag, "_cmd_ready"}, bus.cmd_ready, 1);
   endtask

   initial begin
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      bus.prdata    = '0;
      bus.pready    = 1'b0;
      exp_pwdata    = '0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);

      @(negedge pclk);
      @(negedge pclk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge pclk);

      // Directed scenarios
      xfer(1'b1, 8'h12, 16'hBEEF, 0, 0);
      xfer(1'b0, 8'h12, 16'h0000, 0, 0);
      xfer(1'b0, 8'h12, 16'h5555, 3, 0);
      xfer(1'b0, 8'h40, 16'h0000, TIMEOUT, 0);
      xfer(1'b0, 8'h40, 16'h0000, TIMEOUT - 1, 0);
      xfer(1'b1, 8'h34, 16'h1234, TIMEOUT + 2, 0);
      xfer(1'b0, 8'h34, 16'h0000, 2, 5);

      // Reset in the middle of an ACCESS phase
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 8'h77;
      bus.cmd_wdata = 16'hA5A5;
      bus.pready    = 1'b0;
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      @(negedge pclk);
      check_eq("pre_rst_penable", bus.penable, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_psel",    bus.psel, 0);
      check_eq("async_rst_penable", bus.penable, 0);
      @(negedge pclk);
      check_reset_outputs("mid_rst");
      exp_pwdata = '0;
      rst = 1'b0;
      @(negedge pclk);
      check_eq("post_rst_no_rsp", bus.rsp_valid, 0);
      xfer(1'b0, 8'h77, 16'h0000, 1, 0);
      xfer(1'b1, 8'h77, 16'hC3C3, 0, 1);
      xfer(1'b0, 8'h77, 16'h0000, 0, 0);

      // Randomized traffic over a small address window so reads hit earlier writes
      for (int t = 0; t < 150; t++) begin
         logic          wr;
         logic [AW-1:0] addr;
         int            w;
         wr   = 1'(($urandom));
         addr = AW'($urandom_range(0, 15));
         if ($urandom_range(0, 9) < 7) w = $urandom_range(0, 3);
         else                          w = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
         xfer(wr, addr, DW'($urandom), w, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
